// File: rtl/scan_sequencer.sv
// Pass scheduler for the directional edge-detection scan: runs each enabled
// pass (LR, UD, TTL, TTR) over an N x N image, driving the index counter.
module scan_sequencer #(
    parameter int N    = 150,
    parameter int PIXW = 15
) (
    input  logic       clk,
    input  logic       resetIn,
    input  logic       start,
    input  logic [3:0] pass_mask,
    input  logic       abort,
    input  logic       ready,
    input  logic       line_end,
    output logic [2:0] mode,
    output logic       cnt_enb,
    output logic       cnt_reset,
    output logic       busy,
    output logic       pass_done,
    output logic       done,
    output logic [8:0] lines
);

    typedef enum logic [2:0] {IDLE, CLR, RUN, NEXT, DONE, ABRT} state_t;

    localparam logic [PIXW-1:0] LAST_PIX = PIXW'(N * N - 1);

    state_t          state;
    logic [3:0]      mask;
    logic [PIXW-1:0] pixcnt;
    logic            pass_end;
    logic [2:0]      next_mode;

    // Lowest set bit of m at or above index 'from'; 4 means none left.
    function automatic logic [2:0] first_set_from(input logic [3:0] m, input logic [2:0] from);
        logic [2:0] idx;
        idx = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (3'(i) >= from)) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [8:0] sat_inc(input logic [8:0] v);
        return (v == 9'd511) ? v : v + 9'd1;
    endfunction

    assign pass_end  = (state == RUN) && ready && (pixcnt == LAST_PIX);
    assign next_mode = first_set_from(mask, mode + 3'd1);

    // Stall must gate the counter in the same cycle, so enable bypasses the state register.
    assign cnt_enb   = (state == RUN) && ready;
    assign pass_done = pass_end && !abort;
    assign cnt_reset = (state == CLR) || (state == ABRT);
    assign busy      = (state == CLR) || (state == RUN) || (state == NEXT) || (state == ABRT);
    assign done      = (state == DONE);

    always_ff @(posedge clk or posedge resetIn) begin
        if (resetIn) begin
            state  <= IDLE;
            mode   <= 3'd0;
            mask   <= 4'd0;
            pixcnt <= '0;
            lines  <= 9'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mask <= pass_mask;
                        if (pass_mask == 4'd0) begin
                            state <= DONE;
                        end else begin
                            mode  <= first_set_from(pass_mask, 3'd0);
                            state <= CLR;
                        end
                    end
                end
                CLR: begin
                    pixcnt <= '0;
                    lines  <= 9'd0;
                    state  <= abort ? ABRT : RUN;
                end
                RUN: begin
                    if (ready) pixcnt <= pixcnt + 1'b1;
                    if (line_end) lines <= sat_inc(lines);
                    if (abort) state <= ABRT;
                    else if (pass_end) state <= NEXT;
                end
                NEXT: begin
                    if (abort) begin
                        state <= ABRT;
                    end else if (next_mode[2]) begin
                        state <= DONE;
                    end else begin
                        mode  <= next_mode;
                        state <= CLR;
                    end
                end
                DONE:    state <= IDLE;
                ABRT:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scan_sequencer.sv
// Randomized scoreboard bench for scan_sequencer (N=4): a schedule model predicts
// cnt_reset/pass_done/done events and per-cycle cnt_enb/busy; a monitor checks them.
module tb_scan_sequencer;

    localparam int N    = 4;
    localparam int NPIX = N * N;
    localparam int MAXC = 1024;

    logic       clk = 1'b0;
    logic       resetIn, start, abort, ready, line_end;
    logic [3:0] pass_mask;
    logic [2:0] mode;
    logic       cnt_enb, cnt_reset, busy, pass_done, done;
    logic [8:0] lines;

    scan_sequencer #(.N(N), .PIXW(5)) dut (
        .clk(clk), .resetIn(resetIn), .start(start), .pass_mask(pass_mask),
        .abort(abort), .ready(ready), .line_end(line_end), .mode(mode),
        .cnt_enb(cnt_enb), .cnt_reset(cnt_reset), .busy(busy),
        .pass_done(pass_done), .done(done), .lines(lines)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 0 = cnt_reset, 1 = pass_done, 2 = done
        int cyc;
        int md;     // -1 = don't care
        int lns;
    } ev_t;

    ev_t exq[$];
    int  rdy[MAXC], le[MAXC], exp_enb[MAXC], exp_busy[MAXC];
    int  gcyc = 0;
    int  base = 0;
    bit  mon_on = 0;
    int  pend_lines = -1;
    int  errors = 0, checks = 0;

    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (rel cycle %0d)", name, act, expv, gcyc - base);
        end
    endtask

    function automatic ev_t mk(input int k, input int c, input int m, input int l);
        ev_t e;
        e.kind = k; e.cyc = c; e.md = m; e.lns = l;
        return e;
    endfunction

    // Schedule from the rules: CLR 1 cycle, RUN until NPIX ready-high cycles, NEXT 1 cycle.
    task automatic build(input logic [3:0] m, input int abort_at, output int last, output int donec);
        ev_t evs[$];
        int t, c, cnt, lns, lastm, am;
        int lo[4], hi[4];
        for (int i = 0; i < MAXC; i++) begin exp_enb[i] = 0; exp_busy[i] = 0; end
        for (int i = 0; i < 4; i++) begin lo[i] = -1; hi[i] = -1; end
        exq.delete();
        t = 1; lastm = -1; am = -1;
        if (m == 4'd0) begin
            evs.push_back(mk(2, 1, -1, 0));
            donec = 1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (m[i]) begin
                    evs.push_back(mk(0, t, i, 0));
                    c = t; cnt = 0; lns = 0;
                    while (cnt < NPIX) begin
                        c++;
                        if (le[c] != 0) lns = (lns < 511) ? lns + 1 : 511;
                        if (rdy[c] != 0) cnt++;
                        exp_enb[c] = rdy[c];
                    end
                    evs.push_back(mk(1, c, i, lns));
                    lo[i] = t; hi[i] = c + 1;
                    lastm = i;
                    t = c + 2;
                end
            end
            evs.push_back(mk(2, t, lastm, 0));
            donec = t;
        end
        for (int i = 1; i < donec; i++) exp_busy[i] = 1;
        if (abort_at >= 1 && abort_at < donec) begin
            for (int i = 0; i < 4; i++)
                if (lo[i] >= 0 && abort_at >= lo[i] && abort_at <= hi[i]) am = i;
            foreach (evs[j])
                if (evs[j].cyc < abort_at || (evs[j].cyc == abort_at && evs[j].kind == 0))
                    exq.push_back(evs[j]);
            exq.push_back(mk(0, abort_at + 1, am, 0));
            for (int i = abort_at + 1; i < MAXC; i++) begin exp_enb[i] = 0; exp_busy[i] = 0; end
            exp_busy[abort_at + 1] = 2;
            last = abort_at + 2;
        end else begin
            exq = evs;
            last = donec;
        end
    endtask

    // rk: 0 all ready, 1 toggle, 2 random, 3 long stall; lk: 0 random, 1 every 4th pixel, 2 always
    task automatic run_scan(input logic [3:0] m, input int rk, input int lk,
                            input int abort_at, input bit hold);
        int last, donec;
        for (int c = 0; c < MAXC; c++) begin
            case (rk)
                0: rdy[c] = 1;
                1: rdy[c] = c % 2;
                2: rdy[c] = ($urandom_range(0, 3) != 0) ? 1 : 0;
                default: rdy[c] = (c < 600) ? 0 : 1;
            endcase
            case (lk)
                0: le[c] = $urandom_range(0, 1);
                1: le[c] = (c >= 2 && (c - 2) % 4 == 3) ? 1 : 0;
                default: le[c] = 1;
            endcase
        end
        build(m, abort_at, last, donec);
        base = gcyc;
        pend_lines = -1;
        mon_on = 1;
        for (int r = 0; r <= last + 1; r++) begin
            start     = (r == 0) || (hold && r < donec);
            pass_mask = (r == 0) ? m : 4'($urandom);
            ready     = rdy[r][0];
            line_end  = le[r][0];
            abort     = (r == abort_at);
            @(posedge clk); #1;
        end
        mon_on = 0;
        start = 0; abort = 0;
        check("events_left", exq.size(), 0);
        check("lines_pending", pend_lines, -1);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            int  r, k;
            ev_t e;
            r = gcyc - base;
            if (pend_lines >= 0) begin
                check("lines", int'(lines), pend_lines);
                pend_lines = -1;
            end
            check("cnt_enb", int'(cnt_enb), exp_enb[r]);
            if (exp_busy[r] != 2) check("busy", int'(busy), exp_busy[r]);
            if (cnt_reset || pass_done || done) begin
                k = cnt_reset ? 0 : (pass_done ? 1 : 2);
                if (exq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: kind %0d at rel cycle %0d, expected none", k, r);
                end else begin
                    e = exq.pop_front();
                    check("event_kind", k, e.kind);
                    check("event_cycle", r, e.cyc);
                    if (e.md >= 0) check("mode", int'(mode), e.md);
                    if (k == 1) pend_lines = e.lns;
                    check("single_event", int'(cnt_reset) + int'(pass_done) + int'(done), 1);
                end
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_mode"}, int'(mode), 0);
        check({tag, "_lines"}, int'(lines), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_cnt_reset"}, int'(cnt_reset), 0);
        check({tag, "_cnt_enb"}, int'(cnt_enb), 0);
        check({tag, "_pass_done"}, int'(pass_done), 0);
    endtask

    initial begin
        int seen;
        resetIn = 1; start = 0; abort = 0; ready = 1; line_end = 0; pass_mask = 4'hF;
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        resetIn = 0;
        @(posedge clk); #1;

        run_scan(4'b1111, 0, 0, -1, 0);   // all four passes back to back
        run_scan(4'b0101, 0, 0, -1, 0);   // LR then TTL only
        run_scan(4'b0001, 1, 0, -1, 0);   // alternating stalls
        run_scan(4'b1111, 0, 0, 25, 0);   // abort during UD RUN
        run_scan(4'b1111, 0, 0, -1, 0);   // restart begins at LR again
        run_scan(4'b0000, 0, 0, -1, 1);   // empty mask, start held
        run_scan(4'b0001, 0, 1, -1, 0);   // line_end every row
        run_scan(4'b0011, 0, 0, 17, 0);   // abort on the last pixel
        run_scan(4'b0010, 0, 0, 0, 0);    // abort in IDLE is ignored
        run_scan(4'b1000, 0, 0, 19, 0);   // abort in DONE is ignored
        run_scan(4'b0001, 3, 2, -1, 0);   // lines saturation
        for (int i = 0; i < 6; i++)
            run_scan(4'($urandom_range(0, 15)), 2, 0, -1, 0);

        // Asynchronous reset in the middle of a pass.
        start = 1; pass_mask = 4'b0001; ready = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (4) @(posedge clk);
        #1;
        check("pre_reset_busy", int'(busy), 1);
        check("pre_reset_enb", int'(cnt_enb), 1);
        #2 resetIn = 1;
        #1;
        check_zero("async_reset");
        @(posedge clk); #1;
        resetIn = 0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || busy || cnt_enb || cnt_reset) seen++;
        end
        check("after_reset_quiet", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
